l2_cache_array: RTL and testbench
=================================

L2_CACHE_ARRAY -- requirements
Module: l2_cache_array

Interface
REQ-001 Parameter WAYS, default 2, associativity; SHALL be 2 or 4.
REQ-002 Parameter SETS, default 8, sets per way; SHALL be a power of two, at least 2.
REQ-003 Parameter TAG_W, default 9, tag width in bits.
REQ-004 Parameter LINE_W, default 128, line width in bits.
REQ-005 Ports SHALL be exactly as listed below (IW = log2 SETS, WW = log2 WAYS):
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  lookup request.
- rd_index  in  IW  lookup set.
- rd_tag  in  TAG_W  lookup tag.
- rd_done  out  1  lookup result valid; pulses one cycle after rd_en.
- hit  out  1  lookup tag matched a valid way.
- hit_way  out  WW  matching way; 0 when no hit.
- hit_data  out  LINE_W  line of hit_way; 0 when no hit.
- vic_way  out  WW  replacement candidate for rd_index.
- vic_valid, vic_dirty  out  1 each  state of vic_way.
- vic_tag  out  TAG_W  tag of vic_way.
- vic_data  out  LINE_W  line of vic_way, for writeback.
- wr_en  in  1  write request.
- wr_mode  in  2  00 fill, 01 modify, 10 invalidate, 11 no-op.
- wr_index  in  IW  write set.
- wr_way  in  WW  write way.
- wr_tag  in  TAG_W  write tag.
- wr_data  in  LINE_W  write line.

Function
REQ-006 Storage SHALL be valid, dirty, tag and line per (way, set), plus a PLRU state per set: 1 bit for WAYS=2, 3-bit tree for WAYS=4.
REQ-007 Lookup SHALL have 1-cycle latency: on an edge with rd_en=1, register hit, hit_way, hit_data and all vic_* outputs, and assert rd_done for exactly the next cycle.
REQ-008 Outputs SHALL hold their last registered values while rd_en=0; rd_done=0 in those cycles.
REQ-009 hit SHALL be 1 iff exactly one way has valid=1 and a tag equal to rd_tag.
REQ-010 A lookup matching more than one way is illegal; the bench SHALL flag it with an assertion.
REQ-011 Victim SHALL be the lowest-numbered invalid way; if all ways are valid, it SHALL be the PLRU-indicated way.
REQ-012 Fill (00) SHALL set valid=1, dirty=0, and write tag and line.
REQ-013 Modify (01) SHALL set valid=1, dirty=1, and write tag and line.
REQ-014 Invalidate (10) SHALL clear valid and dirty and leave tag and line unchanged.
REQ-015 No-op (11) SHALL change nothing.
REQ-016 PLRU SHALL mark a way most-recently-used on a lookup hit and on a fill or modify of that way.
REQ-017 Invalidate, no-op and a lookup miss SHALL NOT change PLRU.
REQ-018 Simultaneous rd_en and wr_en on the same set: the lookup SHALL see the pre-write contents (read-before-write).
REQ-019 In the REQ-018 case, the PLRU update from the write SHALL be applied after the update from the lookup hit, so the written way ends up most-recently-used.
REQ-020 Simultaneous rd_en and wr_en on different sets SHALL be independent.
REQ-021 Index values SHALL wrap naturally within IW bits; no out-of-range behaviour exists.

Reset
REQ-022 While rst=1, all valid bits, dirty bits and PLRU state SHALL be cleared asynchronously.
REQ-023 While rst=1, all outputs SHALL be 0.
REQ-024 Reset SHALL NOT clear tag or line storage.
REQ-025 A lookup or write in flight when rst asserts SHALL be discarded; rd_done SHALL NOT pulse for it.
REQ-026 The first edge after rst deasserts SHALL accept requests normally.

Structure
REQ-027 Write-mode encodings SHALL be an enum in lc3b_types, and default TAG_W/LINE_W constants SHALL be defined there.
REQ-028 The PLRU update and victim logic SHALL be a sub-module, l2_plru, parametrised by WAYS.

Verification
REQ-029 Reset then lookup: rst pulse, then lookup set 3 tag 0x1A5 -> rd_done=1, hit=0, vic_way=0, vic_valid=0.
REQ-030 Fill then hit (WAYS=4): fill set 5 ways 0-3 with tags 0x10-0x13, then lookup tag 0x12 -> hit=1, hit_way=2, hit_data equals the written line.
REQ-031 PLRU victim (WAYS=4): fill ways 0,1,2,3 in order, then lookup hits on ways 0 and 1 -> vic_way=2.
REQ-032 Dirty writeback: modify set 2 way 1 with tag 0x0FF and data 0xDEAD..., invalidate way 0, then lookup a missing tag -> vic_way=0. Fill way 0, then lookup again -> vic_way=1, vic_dirty=1, vic_tag=0x0FF.
REQ-033 Same-set collision: lookup and fill on set 7 way 0 in the same cycle -> lookup reports hit=0; the following lookup reports hit=1.
REQ-034 Mid-operation reset: assert rst in the cycle after rd_en -> rd_done stays 0 and all valid bits read 0 afterwards.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and default widths for the L2 cache array slice.
package lc3b_types;

  localparam int DEF_TAG_W  = 9;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    WR_FILL   = 2'b00,
    WR_MODIFY = 2'b01,
    WR_INVAL  = 2'b10,
    WR_NOP    = 2'b11
  } wr_mode_e;

endpackage

// File: rtl/l2_plru.sv
// Tree pseudo-LRU update and victim selection for one lookup set and one write set.
module l2_plru #(
  parameter  int WAYS = 2,
  localparam int WW   = $clog2(WAYS),
  localparam int PW   = WAYS - 1
) (
  input  logic [PW-1:0]   rd_state,
  input  logic [WAYS-1:0] rd_valid,
  input  logic            rd_touch,
  input  logic [WW-1:0]   rd_way,
  input  logic            same_set,
  input  logic [PW-1:0]   wr_state,
  input  logic            wr_touch,
  input  logic [WW-1:0]   wr_way,
  output logic [PW-1:0]   rd_next,
  output logic [PW-1:0]   wr_next,
  output logic [WW-1:0]   victim
);

  logic [PW-1:0] rd_mid_s;
  logic [WW-1:0] plru_way_s;
  logic [WW-1:0] inv_way_s;

  // State bits point at the less-recently-used side; a touch points them away from the way.
  if (WAYS == 2) begin : g_two
    assign rd_mid_s   = rd_touch ? ~rd_way : rd_state;
    assign rd_next    = (wr_touch && same_set) ? ~wr_way : rd_mid_s;
    assign wr_next    = wr_touch ? ~wr_way : wr_state;
    assign plru_way_s = rd_state;
  end else begin : g_four
    function automatic logic [2:0] touch(input logic [2:0] s, input logic [1:0] w);
      logic [2:0] r;
      r    = s;
      r[0] = ~w[1];
      if (w[1]) begin
        r[2] = ~w[0];
      end else begin
        r[1] = ~w[0];
      end
      return r;
    endfunction

    assign rd_mid_s   = rd_touch ? touch(rd_state, rd_way) : rd_state;
    assign rd_next    = (wr_touch && same_set) ? touch(rd_mid_s, wr_way) : rd_mid_s;
    assign wr_next    = wr_touch ? touch(wr_state, wr_way) : wr_state;
    assign plru_way_s = rd_state[0] ? {1'b1, rd_state[2]} : {1'b0, rd_state[1]};
  end

  // Scan from the top so the lowest-numbered invalid way wins.
  always_comb begin
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_way_s = rd_valid[w] ? inv_way_s : WW'(w);
    end
  end

  assign victim = (&rd_valid) ? plru_way_s : inv_way_s;

endmodule

// File: rtl/l2_cache_array.sv
// Set-associative L2 tag/data array with registered lookup, victim reporting and PLRU replacement.
module l2_cache_array
  import lc3b_types::*;
#(
  parameter  int WAYS   = 2,
  parameter  int SETS   = 8,
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int LINE_W = DEF_LINE_W,
  localparam int IW     = $clog2(SETS),
  localparam int WW     = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_index,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_done,
  output logic              hit,
  output logic [WW-1:0]     hit_way,
  output logic [LINE_W-1:0] hit_data,
  output logic [WW-1:0]     vic_way,
  output logic              vic_valid,
  output logic              vic_dirty,
  output logic [TAG_W-1:0]  vic_tag,
  output logic [LINE_W-1:0] vic_data,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [IW-1:0]     wr_index,
  input  logic [WW-1:0]     wr_way,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  localparam int PW = WAYS - 1;

  logic [WAYS-1:0]   valid_r [SETS];
  logic [WAYS-1:0]   dirty_r [SETS];
  logic [PW-1:0]     plru_r  [SETS];
  logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
  logic [LINE_W-1:0] line_r  [WAYS][SETS];

  logic [WAYS-1:0]   match_s;
  logic              hit_s;
  logic [WW-1:0]     hit_way_s;
  logic [LINE_W-1:0] hit_data_s;
  logic [WW-1:0]     victim_s;
  logic              wr_touch_s;
  logic              same_set_s;
  logic [PW-1:0]     plru_rd_next_s;
  logic [PW-1:0]     plru_wr_next_s;

  // Tag compare against the pre-write contents of the lookup set.
  always_comb begin
    match_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_r[rd_index][w] && (tag_r[w][rd_index] == rd_tag);
    end
  end

  assign hit_s = $onehot(match_s);

  // OR-reduce over ways; the hit gate below zeroes the result on miss or multi-match.
  always_comb begin
    hit_way_s  = '0;
    hit_data_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s  = hit_way_s  | (match_s[w] ? WW'(w) : '0);
      hit_data_s = hit_data_s | (match_s[w] ? line_r[w][rd_index] : '0);
    end
  end

  assign wr_touch_s = wr_en && ((wr_mode == WR_FILL) || (wr_mode == WR_MODIFY));
  assign same_set_s = (rd_index == wr_index);

  l2_plru #(.WAYS(WAYS)) u_plru (
    .rd_state (plru_r[rd_index]),
    .rd_valid (valid_r[rd_index]),
    .rd_touch (hit_s),
    .rd_way   (hit_way_s),
    .same_set (same_set_s),
    .wr_state (plru_r[wr_index]),
    .wr_touch (wr_touch_s),
    .wr_way   (wr_way),
    .rd_next  (plru_rd_next_s),
    .wr_next  (plru_wr_next_s),
    .victim   (victim_s)
  );

  // Valid/dirty/PLRU state; a same-set write is folded into the lookup's PLRU result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      if (wr_en) begin
        case (wr_mode_e'(wr_mode))
          WR_FILL: begin
            valid_r[wr_index][wr_way] <= 1'b1;
            dirty_r[wr_index][wr_way] <= 1'b0;
          end
          WR_MODIFY: begin
            valid_r[wr_index][wr_way] <= 1'b1;
            dirty_r[wr_index][wr_way] <= 1'b1;
          end
          WR_INVAL: begin
            valid_r[wr_index][wr_way] <= 1'b0;
            dirty_r[wr_index][wr_way] <= 1'b0;
          end
          WR_NOP: begin
          end
          default: begin
          end
        endcase
      end
      if (rd_en) begin
        plru_r[rd_index] <= plru_rd_next_s;
      end
      if (wr_touch_s && !(rd_en && same_set_s)) begin
        plru_r[wr_index] <= plru_wr_next_s;
      end
    end
  end

  // Tag and line storage survive reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_touch_s) begin
      tag_r[wr_way][wr_index]  <= wr_tag;
      line_r[wr_way][wr_index] <= wr_data;
    end
  end

  // Lookup result registers hold between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done   <= 1'b0;
      hit       <= 1'b0;
      hit_way   <= '0;
      hit_data  <= '0;
      vic_way   <= '0;
      vic_valid <= 1'b0;
      vic_dirty <= 1'b0;
      vic_tag   <= '0;
      vic_data  <= '0;
    end else if (rd_en) begin
      rd_done   <= 1'b1;
      hit       <= hit_s;
      hit_way   <= hit_s ? hit_way_s : '0;
      hit_data  <= hit_s ? hit_data_s : '0;
      vic_way   <= victim_s;
      vic_valid <= valid_r[rd_index][victim_s];
      vic_dirty <= dirty_r[rd_index][victim_s];
      vic_tag   <= tag_r[victim_s][rd_index];
      vic_data  <= line_r[victim_s][rd_index];
    end else begin
      rd_done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_cache_array.sv
// Directed bench for l2_cache_array (4-way, 8 sets) against a tree-PLRU behavioural model.
module tb_l2_cache_array;

  logic         clk;
  logic         rst;
  logic         rd_en;
  logic [2:0]   rd_index;
  logic [8:0]   rd_tag;
  logic         rd_done;
  logic         hit;
  logic [1:0]   hit_way;
  logic [127:0] hit_data;
  logic [1:0]   vic_way;
  logic         vic_valid;
  logic         vic_dirty;
  logic [8:0]   vic_tag;
  logic [127:0] vic_data;
  logic         wr_en;
  logic [1:0]   wr_mode;
  logic [2:0]   wr_index;
  logic [1:0]   wr_way;
  logic [8:0]   wr_tag;
  logic [127:0] wr_data;

  int n_checks = 0;
  int n_fails  = 0;

  l2_cache_array #(.WAYS(4), .SETS(8), .TAG_W(9), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag),
    .rd_done(rd_done), .hit(hit), .hit_way(hit_way), .hit_data(hit_data),
    .vic_way(vic_way), .vic_valid(vic_valid), .vic_dirty(vic_dirty),
    .vic_tag(vic_tag), .vic_data(vic_data),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_index(wr_index), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: contents per (way,set); PLRU kept as "which half and which way were touched last".
  bit           m_valid   [4][8];
  bit           m_dirty   [4][8];
  bit           m_written [4][8];
  logic [8:0]   m_tag     [4][8];
  logic [127:0] m_line    [4][8];
  int           last_half [8];
  int           last_in_half [8][2];

  logic         exp_rd_done, exp_hit, exp_vic_valid, exp_vic_dirty, exp_vic_known;
  logic [1:0]   exp_hit_way, exp_vic_way;
  logic [127:0] exp_hit_data, exp_vic_data;
  logic [8:0]   exp_vic_tag;

  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  function automatic logic [127:0] mk_line(input logic [8:0] t, input logic [1:0] w);
    return {23'd0, t, 30'd0, w, 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
      last_half[s]       = 1;
      last_in_half[s][0] = 1;
      last_in_half[s][1] = 3;
    end
    exp_rd_done = 1'b0; exp_hit = 1'b0; exp_hit_way = 2'd0; exp_hit_data = 128'd0;
    exp_vic_way = 2'd0; exp_vic_valid = 1'b0; exp_vic_dirty = 1'b0;
    exp_vic_tag = 9'd0; exp_vic_data = 128'd0; exp_vic_known = 1'b1;
  endtask

  task automatic touch(input int s, input int w);
    last_half[s]           = w / 2;
    last_in_half[s][w / 2] = w;
  endtask

  task automatic model_edge();
    int n, hw, vw, s, h, ww;
    if (rst) return;
    exp_rd_done = rd_en;
    if (rd_en) begin
      s = int'(rd_index);
      n = 0; hw = 0;
      for (int w = 0; w < 4; w++) begin
        if (m_valid[w][s] && m_tag[w][s] == rd_tag) begin
          n++; hw = w;
        end
      end
      n_checks++;
      assert (n <= 1) else begin
        n_fails++;
        $display("FAIL multi_hit: set %0d has %0d matching ways, expected at most 1", s, n);
      end
      vw = -1;
      for (int w = 3; w >= 0; w--) if (!m_valid[w][s]) vw = w;
      if (vw < 0) begin
        h  = 1 - last_half[s];
        vw = (last_in_half[s][h] == 2 * h) ? 2 * h + 1 : 2 * h;
      end
      exp_hit       = (n == 1);
      exp_hit_way   = exp_hit ? 2'(hw) : 2'd0;
      exp_hit_data  = exp_hit ? m_line[hw][s] : 128'd0;
      exp_vic_way   = 2'(vw);
      exp_vic_valid = m_valid[vw][s];
      exp_vic_dirty = m_dirty[vw][s];
      exp_vic_tag   = m_tag[vw][s];
      exp_vic_data  = m_line[vw][s];
      exp_vic_known = m_written[vw][s];
      if (exp_hit) touch(s, hw);
    end
    if (wr_en) begin
      s  = int'(wr_index);
      ww = int'(wr_way);
      case (wr_mode)
        2'b00, 2'b01: begin
          m_valid[ww][s]   = 1'b1;
          m_dirty[ww][s]   = wr_mode[0];
          m_tag[ww][s]     = wr_tag;
          m_line[ww][s]    = wr_data;
          m_written[ww][s] = 1'b1;
          touch(s, ww);
        end
        2'b10: begin
          m_valid[ww][s] = 1'b0;
          m_dirty[ww][s] = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic re, input logic [2:0] ri, input logic [8:0] rt,
                     input logic we, input logic [1:0] wm, input logic [2:0] wi,
                     input logic [1:0] ww, input logic [8:0] wt, input logic [127:0] wd);
    rd_en = re; rd_index = ri; rd_tag = rt;
    wr_en = we; wr_mode = wm; wr_index = wi; wr_way = ww; wr_tag = wt; wr_data = wd;
    @(posedge clk);
    model_edge();
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] i, input logic [8:0] t);
    cyc(1'b1, i, t, 1'b0, 2'b11, 3'd0, 2'd0, 9'd0, 128'd0);
  endtask

  task automatic wr(input logic [1:0] m, input logic [2:0] i, input logic [1:0] w,
                    input logic [8:0] t, input logic [127:0] d);
    cyc(1'b0, 3'd0, 9'd0, 1'b1, m, i, w, t, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Every cycle, all outputs must equal the model (they hold between lookups).
  always @(negedge clk) begin
    chk("rd_done",   rd_done,   exp_rd_done);
    chk("hit",       hit,       exp_hit);
    chk("hit_way",   hit_way,   exp_hit_way);
    chk("hit_data",  hit_data,  exp_hit_data);
    chk("vic_way",   vic_way,   exp_vic_way);
    chk("vic_valid", vic_valid, exp_vic_valid);
    chk("vic_dirty", vic_dirty, exp_vic_dirty);
    if (exp_vic_known) begin
      chk("vic_tag",  vic_tag,  exp_vic_tag);
      chk("vic_data", vic_data, exp_vic_data);
    end
  end

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_index = 3'd0; rd_tag = 9'd0;
    wr_en = 1'b0; wr_mode = 2'b11; wr_index = 3'd0; wr_way = 2'd0; wr_tag = 9'd0; wr_data = 128'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_vic_tag", vic_tag, 9'd0);
    rst = 1'b0;

    // Lookup right after reset: miss, victim way 0 invalid
    rd(3'd3, 9'h1A5);
    chk("r029_rd_done", rd_done, 1'b1);
    chk("r029_hit", hit, 1'b0);
    chk("r029_vic_way", vic_way, 2'd0);
    chk("r029_vic_valid", vic_valid, 1'b0);
    idle(1);
    chk("r029_done_drop", rd_done, 1'b0);

    // Fill set 5 then hit way 2
    for (int w = 0; w < 4; w++) wr(2'b00, 3'd5, 2'(w), 9'h010 + 9'(w), mk_line(9'h010 + 9'(w), 2'(w)));
    rd(3'd5, 9'h012);
    chk("r030_hit", hit, 1'b1);
    chk("r030_hit_way", hit_way, 2'd2);
    chk("r030_hit_data", hit_data, mk_line(9'h012, 2'd2));
    chk("r030_vic_way", vic_way, 2'd0);

    // PLRU: fill 0..3, hit 0 and 1, victim must be way 2
    for (int w = 0; w < 4; w++) wr(2'b00, 3'd6, 2'(w), 9'h060 + 9'(w), mk_line(9'h060 + 9'(w), 2'(w)));
    rd(3'd6, 9'h060);
    rd(3'd6, 9'h061);
    rd(3'd6, 9'h1FF);
    chk("r031_hit", hit, 1'b0);
    chk("r031_vic_way", vic_way, 2'd2);

    // Dirty writeback on set 2
    wr(2'b00, 3'd2, 2'd2, 9'h102, mk_line(9'h102, 2'd2));
    wr(2'b00, 3'd2, 2'd3, 9'h103, mk_line(9'h103, 2'd3));
    wr(2'b01, 3'd2, 2'd1, 9'h0FF, DEAD);
    wr(2'b10, 3'd2, 2'd0, 9'h000, 128'd0);
    rd(3'd2, 9'h055);
    chk("r032_vic_way_a", vic_way, 2'd0);
    chk("r032_vic_valid_a", vic_valid, 1'b0);
    wr(2'b00, 3'd2, 2'd0, 9'h001, mk_line(9'h001, 2'd0));
    rd(3'd2, 9'h102);
    rd(3'd2, 9'h055);
    chk("r032_vic_way_b", vic_way, 2'd1);
    chk("r032_vic_dirty", vic_dirty, 1'b1);
    chk("r032_vic_tag", vic_tag, 9'h0FF);
    chk("r032_vic_data", vic_data, DEAD);
    wr(2'b10, 3'd2, 2'd1, 9'h000, 128'd0);
    rd(3'd2, 9'h055);
    chk("inval_vic_valid", vic_valid, 1'b0);
    chk("inval_vic_dirty", vic_dirty, 1'b0);
    chk("inval_keeps_tag", vic_tag, 9'h0FF);
    wr(2'b11, 3'd2, 2'd1, 9'h123, mk_line(9'h123, 2'd1));
    rd(3'd2, 9'h055);
    chk("nop_keeps_tag", vic_tag, 9'h0FF);
    chk("nop_keeps_data", vic_data, DEAD);

    // Same-set collision: read-before-write, then write applied to PLRU last
    cyc(1'b1, 3'd7, 9'h077, 1'b1, 2'b00, 3'd7, 2'd0, 9'h077, mk_line(9'h077, 2'd0));
    chk("r033_hit_before", hit, 1'b0);
    rd(3'd7, 9'h077);
    chk("r033_hit_after", hit, 1'b1);
    chk("r033_hit_way", hit_way, 2'd0);
    for (int w = 1; w < 4; w++) wr(2'b00, 3'd7, 2'(w), 9'h070 + 9'(w), mk_line(9'h070 + 9'(w), 2'(w)));
    cyc(1'b1, 3'd7, 9'h077, 1'b1, 2'b01, 3'd7, 2'd3, 9'h0A3, mk_line(9'h0A3, 2'd3));
    chk("coll_hit_way", hit_way, 2'd0);
    rd(3'd7, 9'h1FF);
    chk("coll_plru_vic", vic_way, 2'd1);
    chk("coll_plru_tag", vic_tag, 9'h071);

    // Different sets in the same cycle are independent
    cyc(1'b1, 3'd5, 9'h010, 1'b1, 2'b00, 3'd4, 2'd0, 9'h044, mk_line(9'h044, 2'd0));
    chk("indep_hit_way", hit_way, 2'd0);
    rd(3'd4, 9'h044);
    chk("indep_hit", hit, 1'b1);
    chk("indep_vic_way", vic_way, 2'd1);

    // Reset in the cycle after a lookup
    rd(3'd5, 9'h011);
    rst = 1'b1;
    model_reset();
    #1;
    chk("r034_rd_done", rd_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(3'd5, 9'h012);
    chk("r034_first_done", rd_done, 1'b1);
    chk("r034_hit", hit, 1'b0);
    chk("r034_vic_valid", vic_valid, 1'b0);
    chk("r034_tag_kept", vic_tag, 9'h010);
    rd(3'd7, 9'h077);
    chk("r034_hit7", hit, 1'b0);
    chk("r034_vic_valid7", vic_valid, 1'b0);
    rd(3'd2, 9'h0FF);
    chk("r034_hit2", hit, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
